dbus_arbiter: RTL and testbench
===============================

Name: dbus_arbiter

Overview:
- Arbitrates N bus masters (core0 dbus, debug module, future DMA) onto the single upstream master port that feeds the dbus address decoder.
- Uses round-robin grant with ownership held across back-to-back transactions.
- Enforces a fairness cap and a per-transaction timeout that returns berror, so a hung slave cannot lock the bus.

Parameters:
- N_MASTERS, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 256, cycles from bstart to forced error completion.
- MAX_XFERS, 4, transactions an owner may complete before a forced release while another master is requesting.

Ports:
- clk  in  1  bus clock
- rst_n  in  1  asynchronous active-low reset
- m_breq  in  N_MASTERS  per-master bus request
- m_bgnt  out  N_MASTERS  per-master grant, one-hot or zero
- m_bstart  in  N_MASTERS  per-master transaction start pulse
- m_addr  in  32*N_MASTERS  packed addresses, master i at [32i+31:32i]
- m_wdata  in  32*N_MASTERS  packed write data
- m_tsize  in  2*N_MASTERS  packed size (0 byte, 1 half, 2 word)
- m_ttype  in  N_MASTERS  0 read, 1 write
- m_rdata  out  32  read data, broadcast to all masters
- m_bdone  out  N_MASTERS  per-master completion pulse
- m_berror  out  N_MASTERS  per-master error, valid with m_bdone
- s_addr  out  32  to decoder
- s_wdata  out  32  to decoder
- s_tsize  out  2  to decoder
- s_ttype  out  1  to decoder
- s_bstart  out  1  to decoder
- s_rdata  in  32  from decoder
- s_bdone  in  1  from decoder
- s_berror  in  1  from decoder
- s_breq  out  1  high while any master owns the bus

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE; all outputs 0.
  - last_owner = N_MASTERS-1, so master 0 wins the first tie.
  - xfer_cnt = 0; timer = 0.
- States: IDLE, OWNED, BUSY.
- IDLE: on any m_breq, owner = first requester searching from last_owner+1 with wrap-around. Register owner and go to OWNED. m_bgnt[owner] rises the next cycle, giving 1-cycle grant latency.
- OWNED:
  - s_addr/s_wdata/s_tsize/s_ttype are muxed from owner combinationally; s_bstart = m_bstart[owner].
  - m_bstart[owner] -> BUSY, timer cleared.
  - m_breq[owner] low with no bstart -> IDLE; bgnt drops the next cycle; last_owner = owner.
  - bstart from a non-owner is ignored.
- BUSY:
  - Request signals are held muxed from owner.
  - s_bdone -> pulse m_bdone[owner] and m_berror[owner]=s_berror for exactly that cycle; m_rdata = s_rdata on that cycle, 0 otherwise. Increment xfer_cnt and return to OWNED.
  - timer reaches TIMEOUT_CYCLES-1 without s_bdone -> pulse m_bdone[owner]=1, m_berror[owner]=1, m_rdata=0, return to OWNED. A late s_bdone in OWNED/IDLE is ignored.
  - Owner dropping breq in BUSY is ignored until completion.
- Fairness: on completion, if xfer_cnt reaches MAX_XFERS and any other m_breq is high -> IDLE, bgnt drops, last_owner = owner, xfer_cnt = 0. xfer_cnt also clears on every release.
- Non-owners always see m_bdone=0 and m_berror=0.
- s_bstart is 0 outside OWNED.
- Timer width is clog2(TIMEOUT_CYCLES)+1; it saturates and never wraps.
- Same-cycle owner release and other requests: release takes effect first; re-arbitration happens in IDLE the following cycle. This costs 1 idle cycle between owners.
- Reset mid-BUSY: immediate abort with all outputs 0 and no bdone to the owner.

Test Plan:
- Single master: reset, m_breq=01, bstart read addr 0xF000_0010, slave bdone after 3 cycles with rdata 0xDEADBEEF -> bgnt=01 one cycle after breq; m_bdone[0] pulse 1 cycle with m_rdata=0xDEADBEEF, berror=0.
- Tie: both breq raised the same cycle after reset -> master 0 granted. Master 0 releases after 1 transfer -> master 1 granted 2 cycles later.
- Fairness, MAX_XFERS=4: master 0 issues 6 back-to-back transfers while master 1 requests -> after the 4th bdone, bgnt[0] drops and bgnt[1] rises 2 cycles later.
- Timeout, TIMEOUT_CYCLES=16: slave never asserts bdone -> exactly 16 cycles after bstart, m_bdone[0]=m_berror[0]=1 for one cycle. A later stray s_bdone produces no m_bdone.
- Isolation: master 1 pulses bstart while master 0 owns -> s_bstart stays 0 and s_addr keeps master 0's value.
- Reset in BUSY: rst_n low 2 cycles into a transfer -> all outputs 0 asynchronously. After release, master 0 still wins the first tie.

Source files
------------

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter that connects N dbus masters to the single upstream decoder port.
// The owner keeps the bus across back-to-back transfers, up to a fairness cap and a per-transfer timeout.
module dbus_arbiter #(
  parameter int unsigned N_MASTERS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned MAX_XFERS      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_MASTERS-1:0]    m_breq,
  output logic [N_MASTERS-1:0]    m_bgnt,
  input  logic [N_MASTERS-1:0]    m_bstart,
  input  logic [32*N_MASTERS-1:0] m_addr,
  input  logic [32*N_MASTERS-1:0] m_wdata,
  input  logic [2*N_MASTERS-1:0]  m_tsize,
  input  logic [N_MASTERS-1:0]    m_ttype,
  output logic [31:0]             m_rdata,
  output logic [N_MASTERS-1:0]    m_bdone,
  output logic [N_MASTERS-1:0]    m_berror,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  output logic [1:0]              s_tsize,
  output logic                    s_ttype,
  output logic                    s_bstart,
  input  logic [31:0]             s_rdata,
  input  logic                    s_bdone,
  input  logic                    s_berror,
  output logic                    s_breq
);

  localparam int unsigned OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned XW = $clog2(MAX_XFERS + 1);

  typedef enum logic [1:0] {IDLE, OWNED, BUSY} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   owner, owner_nxt;
  logic [OW-1:0]   last_owner, last_nxt;
  logic [XW-1:0]   xfer_cnt, xfer_nxt;
  logic [TW-1:0]   timer, timer_nxt;

  logic [N_MASTERS-1:0]   own_oh;
  logic [31:0]            addr_sel, wdata_sel;
  logic [1:0]             tsize_sel;
  logic                   ttype_sel;
  logic                   own_req, own_start, others_req;
  logic                   timed_out, complete, active;
  logic [2*N_MASTERS-1:0] req_rot;
  logic [OW-1:0]          rr_pick;
  logic                   rr_found;

  // Rotate the request vector so bit 0 is the master just after last_owner.
  always_comb begin : arbitrate
    int unsigned sum;
    req_rot  = {m_breq, m_breq} >> (32'(last_owner) + 1);
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      sum = 32'(last_owner) + k + 1;
      if (sum >= N_MASTERS) sum = sum - N_MASTERS;
      if (!rr_found && req_rot[k]) begin
        rr_found = 1'b1;
        rr_pick  = OW'(sum);
      end
    end
  end

  always_comb begin : owner_mux
    own_oh    = '0;
    addr_sel  = '0;
    wdata_sel = '0;
    tsize_sel = '0;
    ttype_sel = 1'b0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (owner == OW'(i)) begin
        own_oh[i] = 1'b1;
        addr_sel  = m_addr[32*i +: 32];
        wdata_sel = m_wdata[32*i +: 32];
        tsize_sel = m_tsize[2*i +: 2];
        ttype_sel = m_ttype[i];
      end
    end
  end

  assign own_req    = |(m_breq & own_oh);
  assign own_start  = |(m_bstart & own_oh);
  assign others_req = |(m_breq & ~own_oh);
  assign timed_out  = (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(N_MASTERS - 1);
      xfer_cnt   <= '0;
      timer      <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_nxt;
      xfer_cnt   <= xfer_nxt;
      timer      <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_owner;
    xfer_nxt  = xfer_cnt;
    timer_nxt = timer;
    complete  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rr_found) begin
          owner_nxt = rr_pick;
          state_nxt = OWNED;
        end
      end
      OWNED: begin
        if (own_start) begin
          state_nxt = BUSY;
          timer_nxt = '0;
        end else if (!own_req) begin
          state_nxt = IDLE;
          last_nxt  = owner;
          xfer_nxt  = '0;
        end
      end
      BUSY: begin
        if (s_bdone || timed_out) begin
          complete  = 1'b1;
          state_nxt = OWNED;
          // Cap check uses the pre-increment count: this completion is the MAX_XFERS-th.
          if (xfer_cnt >= XW'(MAX_XFERS - 1) && others_req) begin
            state_nxt = IDLE;
            last_nxt  = owner;
            xfer_nxt  = '0;
          end else if (xfer_cnt != XW'(MAX_XFERS)) begin
            xfer_nxt = xfer_cnt + 1'b1;
          end
        end else if (timer != '1) begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign active   = (state != IDLE);
  assign s_breq   = active;
  assign m_bgnt   = active ? own_oh : '0;
  assign s_addr   = active ? addr_sel : '0;
  assign s_wdata  = active ? wdata_sel : '0;
  assign s_tsize  = active ? tsize_sel : '0;
  assign s_ttype  = active & ttype_sel;
  assign s_bstart = (state == OWNED) & own_start;
  assign m_bdone  = complete ? own_oh : '0;
  assign m_berror = (complete && (s_bdone ? s_berror : 1'b1)) ? own_oh : '0;
  assign m_rdata  = (state == BUSY && s_bdone) ? s_rdata : '0;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed vector table, hand-written multi-cycle sequences,
// then random traffic compared against a transaction-level reference model.
module tb_dbus_arbiter;
  localparam int N  = 2;
  localparam int TO = 16;
  localparam int MX = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_breq, m_bgnt, m_bstart, m_ttype, m_bdone, m_berror;
  logic [32*N-1:0] m_addr, m_wdata;
  logic [2*N-1:0]  m_tsize;
  logic [31:0]     m_rdata, s_addr, s_wdata, s_rdata;
  logic [1:0]      s_tsize;
  logic            s_ttype, s_bstart, s_bdone, s_berror, s_breq;
  logic [106:0]    obus;

  always #5 clk = ~clk;

  dbus_arbiter #(.N_MASTERS(N), .TIMEOUT_CYCLES(TO), .MAX_XFERS(MX)) dut (
    .clk(clk), .rst_n(rst_n), .m_breq(m_breq), .m_bgnt(m_bgnt), .m_bstart(m_bstart),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_tsize(m_tsize), .m_ttype(m_ttype),
    .m_rdata(m_rdata), .m_bdone(m_bdone), .m_berror(m_berror), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_tsize(s_tsize), .s_ttype(s_ttype), .s_bstart(s_bstart),
    .s_rdata(s_rdata), .s_bdone(s_bdone), .s_berror(s_berror), .s_breq(s_breq)
  );

  assign obus = {m_bgnt, m_bdone, m_berror, s_breq, s_bstart, s_ttype, s_tsize,
                 m_rdata, s_addr, s_wdata};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m_breq = '0; m_bstart = '0; s_bdone = 1'b0; s_berror = 1'b0; s_rdata = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset", 128'(obus), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    logic [1:0]  breq, bstart;
    logic        sdone, serr;
    logic [31:0] srdata;
    logic [1:0]  e_bgnt, e_bdone, e_berr;
    logic        e_sbstart;
    logic [31:0] e_rdata, e_saddr;
  } vec_t;

  localparam logic [31:0] A0 = 32'hF000_0010;
  localparam logic [31:0] A1 = 32'h1234_5678;

  vec_t tbl[$];

  // reference model state (owner -1 means the bus is free)
  int mo_owner, mo_last, mo_xfers, mo_age;
  bit mo_busy;

  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   nd, k, c;
    bit   seen, found, done;
    logic [1:0]  e_bgnt, e_bdone, e_berr;
    logic        e_sbstart, e_sbreq;
    logic [31:0] e_rdata, e_saddr, e_swdata;
    logic [1:0]  e_tsize;
    logic        e_ttype;

    m_addr = {A1, A0}; m_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    m_tsize = 4'b0110; m_ttype = 2'b01;

    // rst breq bstart sdone serr srdata | bgnt bdone berr sbstart rdata saddr
    tbl.push_back(vec_t'{1, 2'b01, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 32'h0,        32'h0});
    tbl.push_back(vec_t'{0, 2'b01, 2'b01, 0, 0, 32'h0,        2'b01, 2'b00, 2'b00, 1, 32'h0,        A0});
    tbl.push_back(vec_t'{0, 2'b01, 2'b00, 0, 0, 32'hDEADBEEF, 2'b01, 2'b00, 2'b00, 0, 32'h0,        A0});
    tbl.push_back(vec_t'{0, 2'b01, 2'b00, 0, 0, 32'hDEADBEEF, 2'b01, 2'b00, 2'b00, 0, 32'h0,        A0});
    tbl.push_back(vec_t'{0, 2'b01, 2'b00, 1, 0, 32'hDEADBEEF, 2'b01, 2'b01, 2'b00, 0, 32'hDEADBEEF, A0});
    tbl.push_back(vec_t'{0, 2'b00, 2'b00, 1, 0, 32'hDEADBEEF, 2'b01, 2'b00, 2'b00, 0, 32'h0,        A0});
    tbl.push_back(vec_t'{0, 2'b00, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 32'h0,        32'h0});
    tbl.push_back(vec_t'{1, 2'b11, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 32'h0,        32'h0});
    tbl.push_back(vec_t'{0, 2'b11, 2'b01, 0, 0, 32'h0,        2'b01, 2'b00, 2'b00, 1, 32'h0,        A0});
    tbl.push_back(vec_t'{0, 2'b11, 2'b10, 0, 0, 32'h0,        2'b01, 2'b00, 2'b00, 0, 32'h0,        A0});
    tbl.push_back(vec_t'{0, 2'b11, 2'b00, 1, 1, 32'hCAFE0001, 2'b01, 2'b01, 2'b01, 0, 32'hCAFE0001, A0});
    tbl.push_back(vec_t'{0, 2'b10, 2'b10, 0, 0, 32'h0,        2'b01, 2'b00, 2'b00, 0, 32'h0,        A0});
    tbl.push_back(vec_t'{0, 2'b10, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 32'h0,        32'h0});
    tbl.push_back(vec_t'{0, 2'b10, 2'b00, 0, 0, 32'h0,        2'b10, 2'b00, 2'b00, 0, 32'h0,        A1});
    tbl.push_back(vec_t'{0, 2'b10, 2'b10, 0, 0, 32'h0,        2'b10, 2'b00, 2'b00, 1, 32'h0,        A1});
    tbl.push_back(vec_t'{0, 2'b00, 2'b00, 0, 0, 32'h0,        2'b10, 2'b00, 2'b00, 0, 32'h0,        A1});
    tbl.push_back(vec_t'{0, 2'b00, 2'b00, 1, 0, 32'h11112222, 2'b10, 2'b10, 2'b00, 0, 32'h11112222, A1});
    tbl.push_back(vec_t'{0, 2'b00, 2'b00, 0, 0, 32'h0,        2'b10, 2'b00, 2'b00, 0, 32'h0,        A1});
    tbl.push_back(vec_t'{0, 2'b00, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 32'h0,        32'h0});
    tbl.push_back(vec_t'{0, 2'b11, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 32'h0,        32'h0});
    tbl.push_back(vec_t'{0, 2'b11, 2'b00, 0, 0, 32'h0,        2'b01, 2'b00, 2'b00, 0, 32'h0,        A0});
    tbl.push_back(vec_t'{0, 2'b00, 2'b00, 0, 0, 32'h0,        2'b01, 2'b00, 2'b00, 0, 32'h0,        A0});
    tbl.push_back(vec_t'{0, 2'b00, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 32'h0,        32'h0});
    tbl.push_back(vec_t'{0, 2'b11, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 32'h0,        32'h0});
    tbl.push_back(vec_t'{0, 2'b11, 2'b00, 0, 0, 32'h0,        2'b10, 2'b00, 2'b00, 0, 32'h0,        A1});
    tbl.push_back(vec_t'{0, 2'b00, 2'b00, 0, 0, 32'h0,        2'b10, 2'b00, 2'b00, 0, 32'h0,        A1});
    tbl.push_back(vec_t'{0, 2'b00, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 2'b00, 0, 32'h0,        32'h0});

    foreach (tbl[i]) begin
      v = tbl[i];
      if (v.rst) do_reset();
      m_breq = v.breq; m_bstart = v.bstart; s_bdone = v.sdone; s_berror = v.serr; s_rdata = v.srdata;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 128'({m_bgnt, m_bdone, m_berror, s_bstart, m_rdata, s_addr}),
          128'({v.e_bgnt, v.e_bdone, v.e_berr, v.e_sbstart, v.e_rdata, v.e_saddr}));
      tick();
    end

    // fairness: master 0 keeps starting transfers while master 1 waits
    do_reset();
    m_breq = 2'b11;
    tick();
    nd = 0;
    for (int x = 0; x < 6 && nd < MX; x++) begin
      m_bstart = 2'b01; s_bdone = 1'b0;
      @(negedge clk);
      chk($sformatf("fair_gnt%0d", x), 128'(m_bgnt), 128'(2'b01));
      tick();
      m_bstart = 2'b00; s_bdone = 1'b1; s_rdata = 32'h100 + 32'(x);
      @(negedge clk);
      chk($sformatf("fair_done%0d", x), 128'({m_bdone, m_rdata}), 128'({2'b01, 32'h100 + 32'(x)}));
      if (m_bdone[0]) nd++;
      tick();
    end
    s_bdone = 1'b0; m_bstart = 2'b01;
    @(negedge clk);
    chk("fair_drop", 128'({m_bgnt, s_bstart}), 128'({2'b00, 1'b0}));
    tick();
    m_bstart = 2'b00;
    @(negedge clk);
    chk("fair_m1", 128'({m_bgnt, s_addr}), 128'({2'b10, A1}));
    tick();

    // timeout: slave never answers
    do_reset();
    m_breq = 2'b01;
    tick();
    m_bstart = 2'b01;
    @(negedge clk);
    chk("to_start", 128'(s_bstart), 128'(1'b1));
    tick();
    m_bstart = 2'b00; s_rdata = 32'h5555_AAAA;
    k = 0; seen = 1'b0;
    while (k < 40 && !seen) begin
      k++;
      @(negedge clk);
      if (m_bdone != 2'b00) begin
        seen = 1'b1;
        chk("to_cycles", 128'(k), 128'(16));
        chk("to_err", 128'({m_bdone, m_berror, m_rdata}), 128'({2'b01, 2'b01, 32'h0}));
      end
      tick();
    end
    if (!seen) chk("to_expired", 128'(seen), 128'(1'b1));
    s_bdone = 1'b1;
    @(negedge clk);
    chk("to_stray_owned", 128'({m_bdone, m_berror, m_rdata}), '0);
    tick();
    m_breq = 2'b00;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("to_stray_idle", 128'({m_bgnt, m_bdone, m_berror, m_rdata}), '0);
    tick();
    s_bdone = 1'b0;

    // asynchronous reset in the middle of a transfer
    do_reset();
    m_breq = 2'b11;
    tick();
    m_bstart = 2'b01;
    tick();
    m_bstart = 2'b00;
    tick();
    s_bdone = 1'b1; s_rdata = 32'h7777_0000;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("rst_async", 128'(obus), '0);
    s_bdone = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle", 128'(m_bgnt), '0);
    tick();
    @(negedge clk);
    chk("rst_tie", 128'(m_bgnt), 128'(2'b01));
    tick();

    // random traffic against the reference model
    do_reset();
    mo_owner = -1; mo_last = N - 1; mo_xfers = 0; mo_age = 0; mo_busy = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int m = 0; m < N; m++) begin
        if ($urandom_range(0, 5) == 0) m_breq[m] = ~m_breq[m];
        m_bstart[m] = ($urandom_range(0, 1) == 0);
        m_addr[32*m +: 32]  = $urandom;
        m_wdata[32*m +: 32] = $urandom;
        m_tsize[2*m +: 2]   = 2'($urandom_range(0, 2));
        m_ttype[m]          = 1'($urandom_range(0, 1));
      end
      s_bdone  = ($urandom_range(0, 4) == 0);
      s_berror = 1'($urandom_range(0, 1));
      s_rdata  = $urandom;

      e_bgnt = '0; e_bdone = '0; e_berr = '0; e_rdata = '0;
      e_saddr = '0; e_swdata = '0; e_tsize = '0; e_ttype = 1'b0;
      e_sbreq = (mo_owner >= 0); e_sbstart = 1'b0; done = 1'b0;
      if (mo_owner >= 0) begin
        e_bgnt[mo_owner] = 1'b1;
        e_saddr  = m_addr[32*mo_owner +: 32];
        e_swdata = m_wdata[32*mo_owner +: 32];
        e_tsize  = m_tsize[2*mo_owner +: 2];
        e_ttype  = m_ttype[mo_owner];
        e_sbstart = !mo_busy && m_bstart[mo_owner];
        if (mo_busy) begin
          done = s_bdone || (mo_age == TO - 1);
          if (done) begin
            e_bdone[mo_owner] = 1'b1;
            e_berr[mo_owner]  = s_bdone ? s_berror : 1'b1;
          end
          if (s_bdone) e_rdata = s_rdata;
        end
      end
      @(negedge clk);
      chk($sformatf("rand%0d", cyc), 128'(obus),
          128'({e_bgnt, e_bdone, e_berr, e_sbreq, e_sbstart, e_ttype, e_tsize,
                e_rdata, e_saddr, e_swdata}));

      if (mo_owner < 0) begin
        found = 1'b0;
        for (int j = 1; j <= N; j++) begin
          c = (mo_last + j) % N;
          if (!found && m_breq[c]) begin
            found = 1'b1;
            mo_owner = c;
          end
        end
      end else if (!mo_busy) begin
        if (m_bstart[mo_owner]) begin
          mo_busy = 1'b1; mo_age = 0;
        end else if (!m_breq[mo_owner]) begin
          mo_last = mo_owner; mo_owner = -1; mo_xfers = 0;
        end
      end else if (done) begin
        mo_busy = 1'b0;
        mo_xfers++;
        if (mo_xfers >= MX && (m_breq & ~e_bgnt) != '0) begin
          mo_last = mo_owner; mo_owner = -1; mo_xfers = 0;
        end
      end else begin
        mo_age++;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
